switch_event_queue: RTL and testbench

Downstream consumer of the serial switch-board deserializer. It takes each 21-bit parallel switch frame and its active-low frame strobe, debounces every switch over consecutive frames, and keeps a registered stable switch image. Each debounced state change is queued as a press/release event in a small FIFO, which the control logic drains through a valid/ready interface.

---
 rtl/switch_event_queue_if.sv | 21 ++
 rtl/switch_event_queue.sv | 146 ++++++++++++++
 tb/tb_switch_event_queue.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_event_queue_if.sv
// rtl/switch_event_queue_if.sv - switch event stream between the queue and its consumer
interface switch_event_queue_if;
   logic       ev_valid;
   logic       ev_ready;
   logic [4:0] ev_index;
   logic       ev_pressed;

   modport master (
      output ev_valid,
      output ev_index,
      output ev_pressed,
      input  ev_ready
   );

   modport slave (
      input  ev_valid,
      input  ev_index,
      input  ev_pressed,
      output ev_ready
   );
endinterface

// File: rtl/switch_event_queue.sv
// rtl/switch_event_queue.sv - per-switch frame debounce, stable image and press/release event FIFO
module switch_event_queue #(
   parameter int DEBOUNCE_FRAMES = 4,
   parameter int FIFO_DEPTH      = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          frame_latch_n_i,
   input  logic [20:0]                   frame_in_i,
   output logic [20:0]                   stable_o,
   output logic                          changed_o,
   switch_event_queue_if.master          ev,
   output logic                          ev_overflow_o,
   output logic [$clog2(FIFO_DEPTH):0]   ev_count_o
);

   localparam int NSW = 21;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam logic [3:0]    DB_LAST = 4'(DEBOUNCE_FRAMES - 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic              lat_q;
   logic              accept;
   logic [NSW-1:0]    stable_q, stable_d;
   logic [NSW-1:0]    toggle;
   logic [3:0]        cnt_q [NSW];
   logic [3:0]        cnt_d [NSW];
   logic              changed_q;
   logic [NSW-1:0]    pend_q, pend_d;
   logic [NSW-1:0]    scan_clr;
   logic [4:0]        scan_idx;
   logic              scan_hit;
   logic              overflow_q, overflow_d;
   logic              push, pop;
   logic [5:0]        mem_q [FIFO_DEPTH];
   logic [5:0]        head;
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q, count_d;

   // A strobe held low is one frame: only the falling edge is accepted.
   assign accept = ~frame_latch_n_i & lat_q;

   always_comb begin
      stable_d = stable_q;
      toggle   = '0;
      for (int i = 0; i < NSW; i++) begin
         cnt_d[i] = cnt_q[i];
         if (accept) begin
            if (frame_in_i[i] == stable_q[i]) begin
               cnt_d[i] = 4'd0;
            end else if (cnt_q[i] == DB_LAST) begin
               stable_d[i] = ~stable_q[i];
               cnt_d[i]    = 4'd0;
               toggle[i]   = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + 4'd1;
            end
         end
      end
   end

   // Lowest pending switch wins; descending loop leaves the lowest index.
   always_comb begin
      scan_idx = '0;
      scan_hit = |pend_q;
      for (int i = NSW - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            scan_idx = 5'(i);
         end
      end
   end

   assign push = scan_hit && (count_q < DEPTH_C);
   assign pop  = (count_q != '0) && ev.ev_ready;

   always_comb begin
      scan_clr = '0;
      if (push) begin
         scan_clr[scan_idx] = 1'b1;
      end
   end

   // A fresh toggle overrides the clear, so the bit is reported again.
   assign pend_d     = (pend_q & ~scan_clr) | toggle;
   assign overflow_d = overflow_q | (|(toggle & pend_q & ~scan_clr));

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lat_q      <= 1'b1;
         stable_q   <= '0;
         changed_q  <= 1'b0;
         pend_q     <= '0;
         overflow_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         for (int i = 0; i < NSW; i++) begin
            cnt_q[i] <= 4'd0;
         end
      end else begin
         lat_q      <= frame_latch_n_i;
         stable_q   <= stable_d;
         changed_q  <= |toggle;
         pend_q     <= pend_d;
         overflow_q <= overflow_d;
         count_q    <= count_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         for (int i = 0; i < NSW; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Storage needs no reset; the pointers and count define what is valid.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {scan_idx, stable_q[scan_idx]};
      end
   end

   assign head          = mem_q[rd_ptr_q];
   assign ev.ev_valid   = (count_q != '0);
   assign ev.ev_index   = ev.ev_valid ? head[5:1] : 5'd0;
   assign ev.ev_pressed = ev.ev_valid ? head[0] : 1'b0;

   assign stable_o      = stable_q;
   assign changed_o     = changed_q;
   assign ev_overflow_o = overflow_q;
   assign ev_count_o    = count_q;

endmodule

// File: tb/tb_switch_event_queue.sv
// tb/tb_switch_event_queue.sv - scoreboard bench for switch_event_queue
module tb_switch_event_queue;
   localparam int DB    = 4;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        latch_n = 1'b1;
   logic [20:0] frame = '0;
   logic [20:0] stable;
   logic        changed;
   logic        overflow;
   logic [3:0]  count;

   switch_event_queue_if ev();

   switch_event_queue #(.DEBOUNCE_FRAMES(DB), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .frame_latch_n_i(latch_n),
      .frame_in_i     (frame),
      .stable_o       (stable),
      .changed_o      (changed),
      .ev             (ev),
      .ev_overflow_o  (overflow),
      .ev_count_o     (count)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   logic [5:0]  sb [$];
   logic [5:0]  exp_ev;
   logic [20:0] ref_stable = '0;
   logic [3:0]  ref_cnt [21];
   bit          auto_sb = 1'b1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && ev.ev_valid === 1'b1 && ev.ev_ready === 1'b1) begin
         if (sb.size() == 0) begin
            check("ev_unexpected", sb.size(), 1);
         end else begin
            exp_ev = sb.pop_front();
            check("ev_head", {ev.ev_index, ev.ev_pressed}, exp_ev);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic model_reset();
      ref_stable = '0;
      for (int i = 0; i < 21; i++) ref_cnt[i] = 4'd0;
      sb.delete();
   endtask

   task automatic model_frame(input logic [20:0] v, output logic [20:0] tog);
      tog = '0;
      for (int i = 0; i < 21; i++) begin
         if (v[i] == ref_stable[i]) begin
            ref_cnt[i] = 4'd0;
         end else if (int'(ref_cnt[i]) + 1 == DB) begin
            ref_stable[i] = ~ref_stable[i];
            ref_cnt[i] = 4'd0;
            tog[i] = 1'b1;
         end else begin
            ref_cnt[i] = ref_cnt[i] + 4'd1;
         end
      end
      if (auto_sb) begin
         for (int i = 0; i < 21; i++) begin
            if (tog[i]) sb.push_back({5'(i), ref_stable[i]});
         end
      end
   endtask

   task automatic frame_edge(input logic [20:0] v);
      logic [20:0] tog;
      frame = v;
      latch_n = 1'b0;
      model_frame(v, tog);
      cyc();
      check("changed", changed, |tog);
      check("stable", stable, ref_stable);
      latch_n = 1'b1;
   endtask

   task automatic frames(input logic [20:0] v, input int n);
      for (int k = 0; k < n; k++) begin
         frame_edge(v);
         idle(3);
      end
   endtask

   task automatic drain(input int max);
      int n = 0;
      while ((count != 0 || sb.size() != 0) && n < max) begin
         cyc();
         n++;
      end
      check("drain_count", count, 0);
      check("drain_sb_left", sb.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      latch_n = 1'b1;
      idle(2);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [20:0] cur;
      logic [20:0] tog;
      model_reset();
      ev.ev_ready = 1'b1;
      frame = '1;

      // Reset with strobes active
      rst = 1'b1;
      latch_n = 1'b0; cyc();
      latch_n = 1'b1; cyc();
      latch_n = 1'b0; cyc();
      check("rst_stable", stable, 0);
      check("rst_changed", changed, 0);
      check("rst_valid", ev.ev_valid, 0);
      check("rst_index", ev.ev_index, 0);
      check("rst_pressed", ev.ev_pressed, 0);
      check("rst_count", count, 0);
      check("rst_overflow", overflow, 0);
      latch_n = 1'b1;
      rst = 1'b0;
      idle(3);
      check("no_strobe_stable", stable, 0);
      check("no_strobe_changed", changed, 0);

      // Debounce on bit 0 with a short run first
      frames(21'h1, 3);
      frames(21'h0, 1);
      frames(21'h1, 3);
      frame_edge(21'h1);
      check("lat_e_valid", ev.ev_valid, 0);
      cyc();
      check("lat_e1_valid", ev.ev_valid, 1);
      check("lat_e1_count", count, 1);
      drain(20);

      // Glitch on bit 7
      cur = 21'h1;
      frames(cur | 21'h80, 3);
      frames(cur, 1);
      frames(cur | 21'h80, 3);
      check("glitch_hold", stable[7], 0);
      frames(cur | 21'h80, 1);
      check("glitch_flip", stable[7], 1);
      drain(20);

      // Three simultaneous toggles drain on consecutive cycles
      cur = 21'h81 | 21'h100000 | 21'h8 | 21'h400;
      frames(cur, 3);
      frame_edge(cur);
      check("multi_cnt_e", count, 0);
      cyc(); check("multi_cnt_e1", count, 1);
      cyc(); check("multi_cnt_e2", count, 1);
      cyc(); check("multi_cnt_e3", count, 1);
      cyc(); check("multi_cnt_e4", count, 0);
      check("multi_sb_left", sb.size(), 0);

      // Strobe held low for five cycles is one frame
      cur = cur | 21'h2;
      frame = cur;
      latch_n = 1'b0;
      model_frame(cur, tog);
      idle(5);
      latch_n = 1'b1;
      idle(3);
      check("held_low_stable", stable, ref_stable);
      frames(cur, 3);
      check("held_low_flip", stable[1], 1);
      drain(20);

      // Backpressure: ten toggles into an eight-entry FIFO
      do_reset();
      ev.ev_ready = 1'b0;
      frames(21'h3FF, 4);
      idle(12);
      check("bp_count_full", count, 8);
      check("bp_valid", ev.ev_valid, 1);
      check("bp_overflow", overflow, 0);
      ev.ev_ready = 1'b1;
      drain(60);
      check("bp_overflow_after", overflow, 0);

      // Pending bit re-toggled before it is scanned
      ev.ev_ready = 1'b0;
      auto_sb = 1'b0;
      frames(21'h200, 4);
      idle(8);
      check("merge_count", count, 8);
      check("merge_no_ovf", overflow, 0);
      frames(21'h300, 3);
      frame_edge(21'h300);
      check("merge_ovf", overflow, 1);
      for (int i = 0; i < 8; i++) sb.push_back({5'(i), 1'b0});
      sb.push_back({5'd8, 1'b1});
      auto_sb = 1'b1;
      ev.ev_ready = 1'b1;
      drain(60);
      check("merge_ovf_sticky", overflow, 1);

      // Reset in the middle of a drain
      ev.ev_ready = 1'b0;
      frames(21'h0, 4);
      idle(4);
      check("rstdrain_count", count, 2);
      ev.ev_ready = 1'b1;
      cyc();
      rst = 1'b1;
      cyc();
      check("rstdrain_valid", ev.ev_valid, 0);
      check("rstdrain_count0", count, 0);
      check("rstdrain_stable", stable, 0);
      check("rstdrain_ovf", overflow, 0);
      rst = 1'b0;
      model_reset();
      idle(4);
      check("post_rst_valid", ev.ev_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
